// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two combinational read ports, registered
// PC+increment and a sequenced clear engine. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_param #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned PC_INC = 4
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             ld_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_sel_a_i,
  input  logic [AW-1:0]    rd_sel_b_i,
  output logic [WIDTH-1:0] rd_data_a_o,
  output logic [WIDTH-1:0] rd_data_b_o,
  input  logic             pc_en_i,
  input  logic [WIDTH-1:0] pc_in_i,
  output logic [WIDTH-1:0] pc_out_o,
  input  logic             clr_req_i,
  output logic             clr_busy_o
);

  typedef enum logic {StIdle, StClear} state_e;

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             wr_en;
  logic             clr_en;

  // Writes are only honoured while idle; during a clear they are dropped, not queued.
  assign wr_en  = ld_i && (state_q == StIdle);
  assign clr_en = (state_q == StClear);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (clr_en && (cnt_q == AW'(i))) begin
          regs_q[i] <= '0;
        end else if (wr_en && (wr_addr_i == AW'(i))) begin
          regs_q[i] <= wr_data_i;
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (clr_req_i) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The PC path runs independently of the clear state machine.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q <= '0;
    end else if (pc_en_i) begin
      pc_q <= pc_in_i + WIDTH'(PC_INC);
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_in_range;
  assign wr_in_range = ({1'b0, wr_addr_i} < (AW + 1)'(DEPTH));
`endif

  // Selects at or beyond DEPTH match no entry and read as zero.
  always_comb begin
    rd_data_a_o = '0;
    rd_data_b_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_sel_a_i == AW'(i)) rd_data_a_o = regs_q[i];
      if (rd_sel_b_i == AW'(i)) rd_data_b_o = regs_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_in_range && (wr_addr_i == rd_sel_a_i)) rd_data_a_o = wr_data_i;
    if (wr_en && wr_in_range && (wr_addr_i == rd_sel_b_i)) rd_data_b_o = wr_data_i;
`endif
  end

  assign pc_out_o   = pc_q;
  assign clr_busy_o = busy_q;

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file: one write port, two combinational read ports, a registered PC+increment output, and a sequenced clear engine that zeroes the array one entry per cycle. It sits in the decode stage of the pipeline. It replaces the fixed 16×16 file with a width/depth-configurable array that adds reset and bulk clear.

## Interface
- WIDTH, 32, data and PC bit width
- DEPTH, 16, number of registers (2..2^AW)
- AW, 4, address width
- PC_INC, 4, constant added to pc_in
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ld  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- rd_sel_a  in  AW  read port A select
- rd_sel_b  in  AW  read port B select
- rd_data_a  out  WIDTH  read port A data
- rd_data_b  out  WIDTH  read port B data
- pc_en  in  1  PC output update enable
- pc_in  in  WIDTH  current PC
- pc_out  out  WIDTH  registered pc_in + PC_INC
- clr_req  in  1  start bulk clear (level-sampled)
- clr_busy  out  1  clear in progress

## Operation
- Reset (reset_n low, async): all registers = 0, pc_out = 0, state IDLE, clear counter = 0, clr_busy = 0.
- Write: at rising edge, if ld=1, state IDLE, and wr_addr < DEPTH, reg[wr_addr] <= wr_data. Writes with wr_addr ≥ DEPTH are dropped silently.
- Read: rd_data_x = reg[rd_sel_x], combinational. rd_sel_x ≥ DEPTH returns 0. Both ports may select the same entry.
- PC: at rising edge, if pc_en=1, pc_out <= (pc_in + PC_INC) mod 2^WIDTH. Otherwise it holds. The PC path ignores state.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR when clr_req=1 at an edge; counter <= 0.
  - In CLEAR, each edge: reg[counter] <= 0, counter++. When counter = DEPTH-1, clear that entry and return to IDLE.
  - clr_busy = (state == CLEAR), registered.
  - In CLEAR, ld is ignored (write dropped, not queued) and clr_req is ignored.
  - After returning to IDLE, clr_req still high starts a new clear on the next edge.
- ld and clr_req together in IDLE: the write is performed at that edge, then clearing starts. That entry is zeroed later.
- Reset asserted mid-clear aborts immediately: everything is zeroed and state returns to IDLE.

## Timing
- Write-to-read latency: the new value is visible on rd_data the cycle after the writing edge (or the same cycle with bypass, see Configuration).
- pc_out latency: 1 cycle.
- Clear: clr_req sampled at edge k. clr_busy is high from after edge k through edge k+DEPTH, i.e. exactly DEPTH cycles. reg[i] reads 0 after edge k+1+i. The first accepted write is at edge k+DEPTH+1 or later.
- Reads of not-yet-cleared entries during CLEAR return their old values.
- Counter width is AW. No wrap occurs because the terminal count is DEPTH-1.

## Configuration
- REGFILE_BYPASS_EN defined: if the port's select hits an entry that is being written this cycle (ld=1, state IDLE, wr_addr = rd_sel_x < DEPTH), that port returns wr_data combinationally. Dropped writes, including those during CLEAR, never bypass.
- REGFILE_BYPASS_EN undefined: reads return the stored value only. The written value appears the next cycle.

## Test plan
- Reset: drive reset_n low mid-cycle with registers holding 0xA5A5A5A5 → all rd_data and pc_out read 0 immediately, clr_busy=0.
- Write/read sweep: write reg[i]=0x1010_0000+i for i=0..15, then read with rd_sel_a=i, rd_sel_b=15-i → exact values. Write to wr_addr 12 with DEPTH=12 is dropped; reading 12 returns 0.
- PC: pc_in=0xFFFFFFFE, pc_en=1 → pc_out=0x00000002 after 1 edge. pc_en=0 with pc_in changed → pc_out holds.
- Clear: fill all regs, pulse clr_req at edge k → clr_busy high 16 cycles. reg[3] reads 0 after edge k+4 and reg[4] still holds its old value then. ld=1 to addr 0 with 0x55 during busy → reg[0] stays 0.
- Simultaneous: ld=1 (addr 5, 0x77) and clr_req=1 in IDLE → reg[5]=0x77 after edge k, 0 after edge k+6. Reset at cycle k+3 → clr_busy=0 and all entries 0.
- Bypass, with REGFILE_BYPASS_EN: ld=1, wr_addr=7, wr_data=0xDEAD, rd_sel_a=7 → rd_data_a=0xDEAD in the same cycle. Without the macro → old value that cycle, 0xDEAD the next.
